// File: rtl/uncached_dm_bridge.sv
// rtl/uncached_dm_bridge.sv - MEM-stage uncached load/store to SRAM-like bus bridge
// One transaction outstanding; completed results are held until the MEM stage advances.
module uncached_dm_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_uncached,
  input  logic [31:0] mem_addr,
  input  logic [1:0]  mem_size,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  input  logic        mem_advance,
  input  logic        flush,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  output logic [3:0]  data_sram_wstrb,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        discard_q, discard_d;
  logic [31:0] hold_q, hold_d;
  logic        req_q, req_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        start;

  assign start = (mem_read | mem_write) & mem_uncached & ~flush;

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    hold_d    = hold_q;
    req_d     = req_q;
    wr_d      = wr_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    data_ok   = 1'b0;
    rdata     = hold_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d    = mem_addr;
          size_d    = mem_size;
          wr_d      = mem_write;
          wdata_d   = mem_wdata;
          wstrb_d   = mem_wstrb;
          req_d     = 1'b1;
          discard_d = 1'b0;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (data_sram_addr_ok) begin
          req_d   = 1'b0;
          state_d = S_WAIT;
          if (flush) discard_d = 1'b1;
        end else if (flush) begin
          // Cancelled before the slave accepted: nothing was issued.
          req_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (flush) discard_d = 1'b1;
        if (data_sram_data_ok) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = S_IDLE;
          end else begin
            data_ok = 1'b1;
            rdata   = data_sram_rdata;
            if (mem_advance || flush) begin
              discard_d = 1'b0;
              state_d   = S_IDLE;
            end else begin
              hold_d  = data_sram_rdata;
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        data_ok = 1'b1;
        rdata   = hold_q;
        if (mem_advance || flush) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      discard_q <= 1'b0;
      hold_q    <= 32'h0;
      req_q     <= 1'b0;
      wr_q      <= 1'b0;
      size_q    <= 2'd0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      wstrb_q   <= 4'h0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      hold_q    <= hold_d;
      req_q     <= req_d;
      wr_q      <= wr_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  assign busy            = (state_q != S_IDLE);
  assign data_sram_req   = req_q;
  assign data_sram_wr    = wr_q;
  assign data_sram_size  = size_q;
  assign data_sram_addr  = addr_q;
  assign data_sram_wdata = wdata_q;
  assign data_sram_wstrb = wstrb_q;

endmodule
